wide_alu_reg_master: RTL and testbench

Register-bus initiator that drives a wide ALU through its register file, from the host side. It takes one operation command (two operands, opsel, delay) on a valid/ready port and issues the full write sequence: operands, CTRL2, then trigger. It then polls STATUS, reads back the result words and returns the result plus a completion code. The block sits between an on-chip sequencer and a wide_alu register file, replacing CPU/AXI programming in self-test and accelerator-chaining paths.

---
 rtl/wide_alu_master_pkg.sv | 20 ++
 rtl/wide_alu_reg_xfer.sv | 41 ++++
 rtl/wide_alu_reg_master.sv | 181 ++++++++++++++++++
 tb/tb_wide_alu_reg_master.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wide_alu_master_pkg.sv
// wide_alu_master_pkg: shared states, completion codes and register map of the wide_alu register file
package wide_alu_master_pkg;
   typedef enum logic [3:0] {IDLE, WR_OPA, WR_OPB, WR_CTRL2, WR_TRIG, POLL, CLR_ERR, RD_RES, RESP} state_e;
   typedef enum logic [1:0] {OK = 2'd0, BUS_ERR = 2'd1, ALU_ERR = 2'd2, TIMEOUT = 2'd3} code_e;
   localparam logic [7:0] OPA_OFS = 8'h00;
   localparam logic [7:0] OPB_OFS = 8'h20;
   localparam logic [7:0] RES_OFS = 8'h40;
   localparam logic [7:0] CTRL1_OFS = 8'h80;
   localparam logic [7:0] CTRL2_OFS = 8'h84;
   localparam logic [7:0] STATUS_OFS = 8'h88;
   localparam int CTRL1_TRIGGER = 0;
   localparam int CTRL1_CLEAR_ERR = 1;
   localparam int CTRL2_DELAY_LSB = 8;
   localparam logic [31:0] ST_IDLE = 32'd0;
   localparam logic [31:0] ST_BUSY = 32'd1;
   localparam logic [31:0] ST_ERROR = 32'd2;
   function automatic int max3(input int a, input int b, input int c);
      return (a > b ? a : b) > c ? (a > b ? a : b) : c;
   endfunction
endpackage

// File: rtl/wide_alu_reg_xfer.sv
// wide_alu_reg_xfer: single-transfer register-bus engine; holds the request until valid&ready
module wide_alu_reg_xfer #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  write,
   input  logic [31:0]           wdata,
   input  logic                  reg_ready_i,
   input  logic                  reg_error_i,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] reg_addr_o,
   output logic                  reg_write_o,
   output logic [31:0]           reg_wdata_o,
   output logic [3:0]            reg_wstrb_o,
   output logic                  reg_valid_o
);
   assign done = reg_valid_o & reg_ready_i;
   assign err = done & reg_error_i;
   // a start in the completing cycle keeps valid high for back-to-back transfers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         reg_valid_o <= 1'b0;
         reg_addr_o <= '0;
         reg_write_o <= 1'b0;
         reg_wdata_o <= '0;
         reg_wstrb_o <= '0;
      end else if (start) begin
         reg_valid_o <= 1'b1;
         reg_addr_o <= addr;
         reg_write_o <= write;
         reg_wdata_o <= write ? wdata : 32'h0;
         reg_wstrb_o <= write ? 4'hF : 4'h0;
      end else if (done) begin
         reg_valid_o <= 1'b0;
      end
   end
endmodule

// File: rtl/wide_alu_reg_master.sv
// wide_alu_reg_master: programs a wide ALU over its register bus and returns result plus completion code
module wide_alu_reg_master
   import wide_alu_master_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    OP_WORDS   = 8,
   parameter int                    RES_WORDS  = 16,
   parameter int                    POLL_LIMIT = 1024
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic [32*OP_WORDS-1:0]  cmd_op_a_i,
   input  logic [32*OP_WORDS-1:0]  cmd_op_b_i,
   input  logic [2:0]              cmd_opsel_i,
   input  logic [3:0]              cmd_delay_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [32*RES_WORDS-1:0] rsp_result_o,
   output logic [1:0]              rsp_code_o,
   output logic [ADDR_WIDTH-1:0]   reg_addr_o,
   output logic                    reg_write_o,
   output logic [31:0]             reg_wdata_o,
   output logic [3:0]              reg_wstrb_o,
   output logic                    reg_valid_o,
   input  logic [31:0]             reg_rdata_i,
   input  logic                    reg_error_i,
   input  logic                    reg_ready_i
);
   localparam int CW = $clog2(max3(OP_WORDS, RES_WORDS, POLL_LIMIT) + 1);
   localparam int OIW = OP_WORDS > 1 ? $clog2(OP_WORDS) : 1;
   localparam int RIW = RES_WORDS > 1 ? $clog2(RES_WORDS) : 1;
   state_e state, nxt_state;
   code_e code, nxt_code;
   logic [CW-1:0] idx, nxt_idx, poll, nxt_poll;
   logic [OP_WORDS-1:0][31:0] op_a, op_b, src_a;
   logic [RES_WORDS-1:0][31:0] result;
   logic [2:0] opsel;
   logic [3:0] delay;
   logic accept, done, err, start, wr;
   logic [7:0] ofs;
   logic [31:0] wdata;
   assign cmd_ready_o = state == IDLE;
   assign accept = cmd_ready_o & cmd_valid_i;
   assign rsp_result_o = result;
   assign rsp_code_o = code;
   // the first operand word is issued in the accept cycle, before op_a is latched
   assign src_a = state == IDLE ? cmd_op_a_i : op_a;
   always_comb begin
      nxt_state = state;
      nxt_idx = idx;
      nxt_poll = poll;
      nxt_code = code;
      case (state)
         IDLE: if (cmd_valid_i) begin
            nxt_state = WR_OPA;
            nxt_idx = '0;
            nxt_poll = '0;
            nxt_code = OK;
         end
         WR_OPA: if (done) begin
            nxt_state = idx == CW'(OP_WORDS - 1) ? WR_OPB : WR_OPA;
            nxt_idx = idx == CW'(OP_WORDS - 1) ? '0 : idx + 1'b1;
         end
         WR_OPB: if (done) begin
            nxt_state = idx == CW'(OP_WORDS - 1) ? WR_CTRL2 : WR_OPB;
            nxt_idx = idx == CW'(OP_WORDS - 1) ? '0 : idx + 1'b1;
         end
         WR_CTRL2: if (done) nxt_state = WR_TRIG;
         WR_TRIG: if (done) begin
            nxt_state = POLL;
            nxt_poll = '0;
         end
         POLL: if (done) begin
            nxt_poll = poll + 1'b1;
            if (reg_rdata_i == ST_BUSY) begin
               if (poll == CW'(POLL_LIMIT - 1)) begin
                  nxt_state = RESP;
                  nxt_code = TIMEOUT;
               end
            end else if (reg_rdata_i == ST_ERROR) begin
               nxt_state = CLR_ERR;
            end else begin
               nxt_state = RD_RES;
               nxt_idx = '0;
            end
         end
         CLR_ERR: if (done) begin
            nxt_state = RESP;
            nxt_code = ALU_ERR;
         end
         RD_RES: if (done) begin
            nxt_state = idx == CW'(RES_WORDS - 1) ? RESP : RD_RES;
            nxt_idx = idx + 1'b1;
         end
         RESP: if (rsp_ready_i) nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
      // a bus error on any completed transfer overrides the normal path
      if (err) begin
         nxt_state = RESP;
         nxt_code = BUS_ERR;
      end
      start = (accept | done) & (nxt_state != IDLE) & (nxt_state != RESP);
      wr = (nxt_state != POLL) & (nxt_state != RD_RES);
      ofs = 8'h00;
      wdata = 32'h0;
      case (nxt_state)
         WR_OPA: begin
            ofs = OPA_OFS + {nxt_idx[OIW-1:0], 2'b00};
            wdata = src_a[nxt_idx[OIW-1:0]];
         end
         WR_OPB: begin
            ofs = OPB_OFS + {nxt_idx[OIW-1:0], 2'b00};
            wdata = op_b[nxt_idx[OIW-1:0]];
         end
         WR_CTRL2: begin
            ofs = CTRL2_OFS;
            wdata = (32'(delay) << CTRL2_DELAY_LSB) | 32'(opsel);
         end
         WR_TRIG: begin
            ofs = CTRL1_OFS;
            wdata = 32'h1 << CTRL1_TRIGGER;
         end
         CLR_ERR: begin
            ofs = CTRL1_OFS;
            wdata = 32'h1 << CTRL1_CLEAR_ERR;
         end
         POLL: ofs = STATUS_OFS;
         RD_RES: ofs = RES_OFS + {nxt_idx[RIW-1:0], 2'b00};
         default: ofs = 8'h00;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         code <= OK;
         idx <= '0;
         poll <= '0;
         op_a <= '0;
         op_b <= '0;
         opsel <= '0;
         delay <= '0;
         result <= '0;
         rsp_valid_o <= 1'b0;
      end else begin
         state <= nxt_state;
         code <= nxt_code;
         idx <= nxt_idx;
         poll <= nxt_poll;
         rsp_valid_o <= nxt_state == RESP;
         if (accept) begin
            op_a <= cmd_op_a_i;
            op_b <= cmd_op_b_i;
            opsel <= cmd_opsel_i;
            delay <= cmd_delay_i;
            result <= '0;
         end
         if (state == RD_RES && done && !err) result[idx[RIW-1:0]] <= reg_rdata_i;
      end
   end
   wide_alu_reg_xfer #(.ADDR_WIDTH(ADDR_WIDTH)) u_xfer (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .start(start),
      .addr(BASE_ADDR + ADDR_WIDTH'(ofs)),
      .write(wr),
      .wdata(wdata),
      .reg_ready_i(reg_ready_i),
      .reg_error_i(reg_error_i),
      .done(done),
      .err(err),
      .reg_addr_o(reg_addr_o),
      .reg_write_o(reg_write_o),
      .reg_wdata_o(reg_wdata_o),
      .reg_wstrb_o(reg_wstrb_o),
      .reg_valid_o(reg_valid_o)
   );
endmodule

// File: tb/tb_wide_alu_reg_master.sv
// tb_wide_alu_reg_master: randomized register-bus responder plus transaction-level model of the command sequence
module tb_wide_alu_reg_master;
   import wide_alu_master_pkg::*;
   localparam int OPW = 8;
   localparam int RESW = 16;
   localparam int PL = 4;
   localparam logic [31:0] BASE = 32'h0000_1000;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cmd_valid = 1'b0, cmd_ready;
   logic [32*OPW-1:0] cmd_a = '0, cmd_b = '0;
   logic [2:0] cmd_opsel = '0;
   logic [3:0] cmd_delay = '0;
   logic rsp_valid, rsp_ready = 1'b0;
   logic [32*RESW-1:0] rsp_result;
   logic [1:0] rsp_code;
   logic [31:0] reg_addr, reg_wdata, reg_rdata;
   logic reg_write, reg_valid, reg_error, reg_ready;
   logic [3:0] reg_wstrb;
   int tests = 0, fails = 0;
   int ready_pct = 100, err_at = -1, npoll = 0;
   logic [31:0] status_q[$];
   logic [31:0] res_w[RESW];
   logic [31:0] log_addr[$], log_wd[$], exp_addr[$], exp_wd[$];
   logic log_wr[$], exp_wr[$];
   logic [3:0] log_st[$];
   logic [1:0] exp_code, got_code;
   logic [32*RESW-1:0] exp_res, got_res;
   always #5 clk = ~clk;
   wide_alu_reg_master #(.ADDR_WIDTH(32), .BASE_ADDR(BASE), .OP_WORDS(OPW), .RES_WORDS(RESW), .POLL_LIMIT(PL)) dut (
      .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_op_a_i(cmd_a), .cmd_op_b_i(cmd_b), .cmd_opsel_i(cmd_opsel), .cmd_delay_i(cmd_delay),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result), .rsp_code_o(rsp_code),
      .reg_addr_o(reg_addr), .reg_write_o(reg_write), .reg_wdata_o(reg_wdata), .reg_wstrb_o(reg_wstrb),
      .reg_valid_o(reg_valid), .reg_rdata_i(reg_rdata), .reg_error_i(reg_error), .reg_ready_i(reg_ready)
   );
   // responder: random ready, scripted STATUS, result memory, error injection by transfer number
   initial begin
      logic stall;
      logic [31:0] pa, pd;
      logic pw;
      stall = 1'b0;
      pa = '0;
      pd = '0;
      pw = 1'b0;
      reg_ready = 1'b0;
      reg_error = 1'b0;
      reg_rdata = '0;
      forever begin
         @(negedge clk);
         if (stall && reg_valid) begin
            tests++;
            if (reg_addr !== pa || reg_write !== pw || reg_wdata !== pd) begin
               fails++;
               $display("FAIL hold: addr=%h wr=%b wdata=%h, required addr=%h wr=%b wdata=%h", reg_addr, reg_write, reg_wdata, pa, pw, pd);
            end
         end
         reg_ready = reg_valid && int'($urandom_range(99)) < ready_pct;
         reg_error = 1'b0;
         reg_rdata = '0;
         stall = reg_valid && !reg_ready;
         pa = reg_addr;
         pw = reg_write;
         pd = reg_wdata;
         if (reg_ready) begin
            reg_error = log_addr.size() == err_at;
            if (!reg_write && reg_addr == BASE + 32'h88) begin
               reg_rdata = status_q[npoll < status_q.size() ? npoll : status_q.size() - 1];
               npoll++;
            end else if (!reg_write && reg_addr >= BASE + 32'h40 && reg_addr < BASE + 32'h80) begin
               reg_rdata = res_w[int'((reg_addr - BASE - 32'h40) >> 2)];
            end
            log_addr.push_back(reg_addr);
            log_wr.push_back(reg_write);
            log_wd.push_back(reg_wdata);
            log_st.push_back(reg_wstrb);
         end
      end
   end
   task automatic push(input logic [31:0] a, input logic w, input logic [31:0] d);
      exp_addr.push_back(a);
      exp_wr.push_back(w);
      exp_wd.push_back(d);
   endtask
   // expected transfer list, code and result from the command, STATUS script and injected error
   task automatic model(input logic [32*OPW-1:0] a, input logic [32*OPW-1:0] b, input logic [2:0] os, input logic [3:0] dl);
      logic [31:0] s;
      exp_addr.delete();
      exp_wr.delete();
      exp_wd.delete();
      exp_code = 2'd0;
      exp_res = '0;
      for (int i = 0; i < OPW; i++) push(BASE + 32'(4 * i), 1'b1, a[32*i+:32]);
      for (int i = 0; i < OPW; i++) push(BASE + 32'h20 + 32'(4 * i), 1'b1, b[32*i+:32]);
      push(BASE + 32'h84, 1'b1, (32'(dl) << 8) | 32'(os));
      push(BASE + 32'h80, 1'b1, 32'h1);
      for (int k = 0; k < PL; k++) begin
         s = status_q[k < status_q.size() ? k : status_q.size() - 1];
         push(BASE + 32'h88, 1'b0, 32'h0);
         if (s == 32'd1) begin
            if (k == PL - 1) exp_code = 2'd3;
         end else if (s == 32'd2) begin
            push(BASE + 32'h80, 1'b1, 32'h2);
            exp_code = 2'd2;
            break;
         end else begin
            for (int j = 0; j < RESW; j++) begin
               push(BASE + 32'h40 + 32'(4 * j), 1'b0, 32'h0);
               exp_res[32*j+:32] = res_w[j];
            end
            break;
         end
      end
      if (err_at >= 0 && err_at < exp_addr.size()) begin
         while (exp_addr.size() > err_at + 1) begin
            void'(exp_addr.pop_back());
            void'(exp_wr.pop_back());
            void'(exp_wd.pop_back());
         end
         exp_code = 2'd1;
         exp_res = '0;
         for (int t = 0; t < err_at; t++)
            if (!exp_wr[t] && exp_addr[t] >= BASE + 32'h40 && exp_addr[t] < BASE + 32'h80)
               exp_res[32*int'((exp_addr[t] - BASE - 32'h40) >> 2)+:32] = res_w[int'((exp_addr[t] - BASE - 32'h40) >> 2)];
      end
   endtask
   function automatic int diff_at();
      for (int i = 0; i < exp_addr.size(); i++) begin
         if (i >= log_addr.size()) return i;
         if (log_addr[i] !== exp_addr[i] || log_wr[i] !== exp_wr[i] || log_st[i] !== (exp_wr[i] ? 4'hF : 4'h0) || (exp_wr[i] && log_wd[i] !== exp_wd[i])) return i;
      end
      return log_addr.size() > exp_addr.size() ? exp_addr.size() : -1;
   endfunction
   task automatic issue_cmd(input logic [32*OPW-1:0] a, input logic [32*OPW-1:0] b, input logic [2:0] os, input logic [3:0] dl);
      model(a, b, os, dl);
      log_addr.delete();
      log_wr.delete();
      log_wd.delete();
      log_st.delete();
      npoll = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_a = a;
      cmd_b = b;
      cmd_opsel = os;
      cmd_delay = dl;
      for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask
   task automatic wait_rsp(output bit found);
      for (int i = 0; i < 3000 && !rsp_valid; i++) @(negedge clk);
      found = rsp_valid;
      got_code = rsp_code;
      got_res = rsp_result;
   endtask
   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask
   function automatic logic [32*OPW-1:0] rnd_op();
      logic [32*OPW-1:0] v;
      for (int i = 0; i < OPW; i++) v[32*i+:32] = $urandom();
      return v;
   endfunction
   task automatic test_reset();
      tests++;
      if ({cmd_ready, rsp_valid, reg_valid, reg_write, reg_wstrb, rsp_code} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0}) begin
         fails++;
         $display("FAIL reset ctrl: ready=%b rsp_valid=%b reg_valid=%b write=%b wstrb=%h code=%0d", cmd_ready, rsp_valid, reg_valid, reg_write, reg_wstrb, rsp_code);
      end
      tests++;
      if (reg_addr !== '0 || reg_wdata !== '0 || rsp_result !== '0) begin
         fails++;
         $display("FAIL reset data: addr=%h wdata=%h result nonzero=%b, required 0", reg_addr, reg_wdata, rsp_result != '0);
      end
   endtask
   task automatic test_nominal();
      bit found;
      int d;
      ready_pct = 100;
      err_at = -1;
      status_q = '{32'd1, 32'd1, 32'd0};
      for (int j = 0; j < RESW; j++) res_w[j] = 32'hA5A5_0000 + 32'(j);
      issue_cmd(256'd1, 256'd2, 3'd0, 4'd0);
      wait_rsp(found);
      finish_rsp();
      d = diff_at();
      tests++;
      if (!found || d >= 0) begin
         fails++;
         $display("FAIL nominal seq: response=%b, differs at transfer %0d, got %0d transfers, required %0d", found, d, log_addr.size(), exp_addr.size());
      end
      tests++;
      if (got_code !== exp_code) begin fails++; $display("FAIL nominal code: got %0d, required %0d", got_code, exp_code); end
      tests++;
      if (got_res !== exp_res) begin fails++; $display("FAIL nominal result: got %h, required %h", got_res[63:0], exp_res[63:0]); end
      tests++;
      if (!cmd_ready || rsp_valid) begin fails++; $display("FAIL nominal idle: cmd_ready=%b rsp_valid=%b, required 1/0", cmd_ready, rsp_valid); end
   endtask
   task automatic test_random();
      bit found;
      int d, nb;
      ready_pct = 100;
      err_at = -1;
      for (int r = 0; r < 4; r++) begin
         nb = int'($urandom_range(2));
         status_q.delete();
         for (int k = 0; k < nb; k++) status_q.push_back(32'd1);
         status_q.push_back(r[0] ? 32'd7 : 32'd0);
         for (int j = 0; j < RESW; j++) res_w[j] = $urandom();
         issue_cmd(rnd_op(), rnd_op(), 3'($urandom()), 4'($urandom()));
         wait_rsp(found);
         finish_rsp();
         d = diff_at();
         tests++;
         if (!found || d >= 0) begin fails++; $display("FAIL random seq %0d: response=%b, differs at transfer %0d", r, found, d); end
         tests++;
         if (got_code !== exp_code || got_res !== exp_res) begin fails++; $display("FAIL random rsp %0d: code %0d, required %0d, result match=%b", r, got_code, exp_code, got_res === exp_res); end
      end
   endtask
   task automatic test_backpressure();
      bit found;
      int d;
      ready_pct = 70;
      err_at = -1;
      status_q = '{32'd1, 32'd0};
      for (int j = 0; j < RESW; j++) res_w[j] = $urandom();
      issue_cmd(rnd_op(), rnd_op(), 3'd5, 4'd9);
      wait_rsp(found);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tests++;
         if (!rsp_valid || cmd_ready || rsp_code !== got_code || rsp_result !== got_res) begin
            fails++;
            $display("FAIL backpressure rsp hold %0d: rsp_valid=%b cmd_ready=%b code=%0d, required 1/0/%0d", c, rsp_valid, cmd_ready, rsp_code, got_code);
         end
      end
      finish_rsp();
      ready_pct = 100;
      d = diff_at();
      tests++;
      if (!found || d >= 0) begin fails++; $display("FAIL backpressure seq: response=%b, differs at transfer %0d", found, d); end
      tests++;
      if (got_code !== exp_code || got_res !== exp_res) begin fails++; $display("FAIL backpressure rsp: code %0d, required %0d, result match=%b", got_code, exp_code, got_res === exp_res); end
   endtask
   task automatic test_alu_err();
      bit found;
      int d;
      err_at = -1;
      status_q = '{32'd1, 32'd2};
      issue_cmd(rnd_op(), rnd_op(), 3'd3, 4'd2);
      wait_rsp(found);
      finish_rsp();
      d = diff_at();
      tests++;
      if (!found || d >= 0) begin fails++; $display("FAIL alu_err seq: response=%b, differs at transfer %0d, got %0d transfers, required %0d", found, d, log_addr.size(), exp_addr.size()); end
      tests++;
      if (got_code !== 2'd2 || got_res !== '0) begin fails++; $display("FAIL alu_err rsp: code %0d, required 2, result zero=%b", got_code, got_res == '0); end
   endtask
   task automatic test_timeout();
      bit found;
      int d;
      err_at = -1;
      status_q = '{32'd1};
      issue_cmd(rnd_op(), rnd_op(), 3'd1, 4'd1);
      wait_rsp(found);
      finish_rsp();
      d = diff_at();
      tests++;
      if (!found || d >= 0 || npoll != PL) begin fails++; $display("FAIL timeout seq: response=%b, differs at %0d, STATUS reads %0d, required %0d", found, d, npoll, PL); end
      tests++;
      if (got_code !== 2'd3 || got_res !== '0) begin fails++; $display("FAIL timeout code: got %0d, required 3", got_code); end
   endtask
   task automatic test_bus_error();
      bit found;
      int d;
      int err_pts[2] = '{2 * OPW - 6, 2 * OPW + 2 + 1 + 5};
      status_q = '{32'd0};
      for (int j = 0; j < RESW; j++) res_w[j] = $urandom();
      for (int e = 0; e < 2; e++) begin
         err_at = err_pts[e];
         issue_cmd(rnd_op(), rnd_op(), 3'd6, 4'd4);
         wait_rsp(found);
         finish_rsp();
         d = diff_at();
         tests++;
         if (!found || d >= 0) begin fails++; $display("FAIL bus_err seq %0d: response=%b, differs at %0d, got %0d transfers, required %0d", e, found, d, log_addr.size(), exp_addr.size()); end
         tests++;
         if (got_code !== 2'd1 || got_res !== exp_res) begin fails++; $display("FAIL bus_err rsp %0d: code %0d, required 1, result match=%b", e, got_code, got_res === exp_res); end
      end
      err_at = -1;
      issue_cmd(rnd_op(), rnd_op(), 3'd2, 4'd15);
      wait_rsp(found);
      finish_rsp();
      d = diff_at();
      tests++;
      if (!found || d >= 0 || got_code !== 2'd0 || got_res !== exp_res) begin fails++; $display("FAIL bus_err recovery: response=%b differs at %0d code %0d, required 0", found, d, got_code); end
   endtask
   task automatic test_mid_reset();
      bit rose;
      err_at = -1;
      status_q = '{32'd1, 32'd0};
      issue_cmd(rnd_op(), rnd_op(), 3'd4, 4'd3);
      for (int i = 0; i < 200 && log_addr.size() < OPW + 2; i++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if (reg_valid !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL mid_reset: reg_valid=%b cmd_ready=%b, required 0/1", reg_valid, cmd_ready); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      log_addr.delete();
      log_wr.delete();
      log_wd.delete();
      log_st.delete();
      rose = 1'b0;
      repeat (20) begin
         @(negedge clk);
         rose |= rsp_valid;
      end
      tests++;
      if (rose || log_addr.size() != 0) begin fails++; $display("FAIL mid_reset quiet: rsp_valid rose=%b, transfers %0d, required 0/0", rose, log_addr.size()); end
   endtask
   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_nominal();
      test_random();
      test_backpressure();
      test_alu_err();
      test_timeout();
      test_bus_error();
      test_mid_reset();
      test_nominal();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
